// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared types and select encodings for the MUX2 round-robin arbiter.
package mux2_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT1 = 2'd1,
        GNT2 = 2'd2
    } arb_state_t;

    localparam logic SEL_DATA_1 = 1'b0;
    localparam logic SEL_DATA_2 = 1'b1;

endpackage

// File: rtl/mux2_rr_arbiter_rr_pick2.sv
// Combinational next-winner pick for two requesters: on contention the one not served last wins.
module rr_pick2 (
    input  logic req_1,
    input  logic req_2,
    input  logic last_served,
    output logic any_req,
    output logic pick
);

    always_comb begin
        any_req = req_1 | req_2;
        // pick: 0 = requester 1, 1 = requester 2
        if (req_1 && req_2) begin
            pick = ~last_served;
        end else begin
            pick = req_2;
        end
    end

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Packet-locking round-robin arbiter that sequences the shared MUX2 select line.
// Optional per-requester packet counters are enabled with MUX2_RR_ARB_STATS_EN.
//
// state | meaning
// IDLE  | no owner; next request wins the mux on the following cycle
// GNT1  | requester 1 owns the mux until its packet's final beat
// GNT2  | requester 2 owns the mux until its packet's final beat
module mux2_rr_arbiter
    import mux2_arb_pkg::*;
#(
    parameter int FLITS_PER_PACKET = 4,
    parameter int CNT_W            = $clog2(FLITS_PER_PACKET + 1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_1,
    input  logic        req_2,
    input  logic        out_ready,
    output logic        grant_1,
    output logic        grant_2,
    output logic        ready_1,
    output logic        ready_2,
    output logic        select,
    output logic        out_valid,
`ifdef MUX2_RR_ARB_STATS_EN
    output logic [15:0] pkt_cnt_1,
    output logic [15:0] pkt_cnt_2,
`endif
    output logic        packet_last
);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FLITS_PER_PACKET - 1);

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             last_served_q, last_served_d;
    logic             select_q, select_d;

    logic any_req;
    logic pick;
    logic xfer;
    logic final_beat;

    rr_pick2 u_pick (
        .req_1       (req_1),
        .req_2       (req_2),
        .last_served (last_served_q),
        .any_req     (any_req),
        .pick        (pick)
    );

    always_comb begin
        grant_1     = (state_q == GNT1);
        grant_2     = (state_q == GNT2);
        select      = select_q;
        out_valid   = (grant_1 & req_1) | (grant_2 & req_2);
        ready_1     = grant_1 & req_1 & out_ready;
        ready_2     = grant_2 & req_2 & out_ready;
        xfer        = out_valid & out_ready;
        final_beat  = (beat_cnt_q == LAST_BEAT);
        packet_last = xfer & final_beat;
    end

    always_comb begin
        state_d       = state_q;
        beat_cnt_d    = beat_cnt_q;
        last_served_d = last_served_q;
        select_d      = select_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d  = pick ? GNT2 : GNT1;
                    select_d = pick ? SEL_DATA_2 : SEL_DATA_1;
                end
            end
            GNT1: begin
                if (xfer && final_beat) begin
                    beat_cnt_d    = '0;
                    last_served_d = 1'b0;
                    // hand straight over to a waiting peer so back-to-back packets have no bubble
                    if (req_2) begin
                        state_d  = GNT2;
                        select_d = SEL_DATA_2;
                    end else if (req_1) begin
                        state_d = GNT1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (xfer) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                end
            end
            GNT2: begin
                if (xfer && final_beat) begin
                    beat_cnt_d    = '0;
                    last_served_d = 1'b1;
                    if (req_1) begin
                        state_d  = GNT1;
                        select_d = SEL_DATA_1;
                    end else if (req_2) begin
                        state_d = GNT2;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (xfer) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d    = IDLE;
                beat_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            beat_cnt_q    <= '0;
            last_served_q <= 1'b1;
            select_q      <= SEL_DATA_1;
        end else begin
            state_q       <= state_d;
            beat_cnt_q    <= beat_cnt_d;
            last_served_q <= last_served_d;
            select_q      <= select_d;
        end
    end

`ifdef MUX2_RR_ARB_STATS_EN
    logic [15:0] pkt_cnt_1_q, pkt_cnt_1_d;
    logic [15:0] pkt_cnt_2_q, pkt_cnt_2_d;

    always_comb begin
        pkt_cnt_1_d = pkt_cnt_1_q;
        pkt_cnt_2_d = pkt_cnt_2_q;
        if (packet_last && grant_1 && (pkt_cnt_1_q != 16'hFFFF)) begin
            pkt_cnt_1_d = pkt_cnt_1_q + 16'd1;
        end
        if (packet_last && grant_2 && (pkt_cnt_2_q != 16'hFFFF)) begin
            pkt_cnt_2_d = pkt_cnt_2_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_cnt_1_q <= '0;
            pkt_cnt_2_q <= '0;
        end else begin
            pkt_cnt_1_q <= pkt_cnt_1_d;
            pkt_cnt_2_q <= pkt_cnt_2_d;
        end
    end

    assign pkt_cnt_1 = pkt_cnt_1_q;
    assign pkt_cnt_2 = pkt_cnt_2_q;
`endif

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed table-driven bench for mux2_rr_arbiter with FLITS_PER_PACKET = 4.
module tb_mux2_rr_arbiter;

    localparam logic [6:0] G1  = 7'b1000000;
    localparam logic [6:0] G2  = 7'b0100000;
    localparam logic [6:0] RD1 = 7'b0010000;
    localparam logic [6:0] RD2 = 7'b0001000;
    localparam logic [6:0] SEL = 7'b0000100;
    localparam logic [6:0] OV  = 7'b0000010;
    localparam logic [6:0] PL  = 7'b0000001;
    localparam logic [6:0] Z   = 7'b0000000;

    logic clk = 1'b0;
    logic reset, req_1, req_2, out_ready;
    logic grant_1, grant_2, ready_1, ready_2, select, out_valid, packet_last;
`ifdef MUX2_RR_ARB_STATS_EN
    logic [15:0] pkt_cnt_1, pkt_cnt_2;
`endif

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic       rst;
        logic       r1;
        logic       r2;
        logic       ordy;
        logic [6:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    mux2_rr_arbiter #(.FLITS_PER_PACKET(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_1       (req_1),
        .req_2       (req_2),
        .out_ready   (out_ready),
        .grant_1     (grant_1),
        .grant_2     (grant_2),
        .ready_1     (ready_1),
        .ready_2     (ready_2),
        .select      (select),
        .out_valid   (out_valid),
`ifdef MUX2_RR_ARB_STATS_EN
        .pkt_cnt_1   (pkt_cnt_1),
        .pkt_cnt_2   (pkt_cnt_2),
`endif
        .packet_last (packet_last)
    );

    function automatic vec_t v(input logic rst, input logic r1, input logic r2,
                               input logic ordy, input logic [6:0] exp, input string name);
        vec_t t;
        t.rst = rst; t.r1 = r1; t.r2 = r2; t.ordy = ordy; t.exp = exp; t.name = name;
        return t;
    endfunction

    // Apply inputs for one cycle, check outputs mid-cycle, then advance past the edge.
    task automatic cyc(input logic rst, input logic r1, input logic r2, input logic ordy,
                       input logic [6:0] exp, input string name);
        logic [6:0] act;
        reset = rst; req_1 = r1; req_2 = r2; out_ready = ordy;
        #4;
        act = {grant_1, grant_2, ready_1, ready_2, select, out_valid, packet_last};
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got g1g2rd1rd2 sel ov pl=%b, expected %b", name, act, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; req_1 = 1'b0; req_2 = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #1;

        // reset and idle
        vecs.push_back(v(1, 0, 0, 0, Z, "reset_1"));
        vecs.push_back(v(1, 0, 0, 1, Z, "reset_2"));
        vecs.push_back(v(0, 0, 0, 1, Z, "idle_1"));
        vecs.push_back(v(0, 0, 0, 1, Z, "idle_2"));
        // single requester 2
        vecs.push_back(v(0, 0, 1, 1, Z, "single_req_c0"));
        vecs.push_back(v(0, 0, 1, 1, G2 | RD2 | SEL | OV, "single_beat1"));
        vecs.push_back(v(0, 0, 1, 1, G2 | RD2 | SEL | OV, "single_beat2"));
        vecs.push_back(v(0, 0, 1, 1, G2 | RD2 | SEL | OV, "single_beat3"));
        vecs.push_back(v(0, 0, 1, 1, G2 | RD2 | SEL | OV | PL, "single_beat4_last"));
        vecs.push_back(v(0, 0, 0, 1, G2 | SEL, "single_after_drop"));
        vecs.push_back(v(1, 0, 0, 1, G2 | SEL, "single_reset_1"));
        vecs.push_back(v(1, 0, 0, 1, Z, "single_reset_2"));
        // contention: 6 packets alternating, no idle bubble
        vecs.push_back(v(0, 1, 1, 1, Z, "cont_c0"));
        for (int i = 1; i <= 24; i++) begin
            logic [6:0] e;
            e = (((i - 1) / 4) % 2 == 0) ? (G1 | RD1 | OV) : (G2 | RD2 | SEL | OV);
            if (i % 4 == 0) e = e | PL;
            vecs.push_back(v(0, 1, 1, 1, e, $sformatf("cont_beat%0d", i)));
        end

        foreach (vecs[i]) cyc(vecs[i].rst, vecs[i].r1, vecs[i].r2, vecs[i].ordy,
                              vecs[i].exp, vecs[i].name);

`ifdef MUX2_RR_ARB_STATS_EN
        total++;
        if (pkt_cnt_1 === 16'd3 && pkt_cnt_2 === 16'd3) passed++;
        else $display("FAIL stats_counts: got %0d/%0d, expected 3/3", pkt_cnt_1, pkt_cnt_2);
`endif

        // backpressure after beat 2 of requester 1
        cyc(1, 0, 0, 1, G1, "bp_reset_1");
        cyc(1, 0, 0, 1, Z, "bp_reset_2");
        cyc(0, 1, 0, 1, Z, "bp_c0");
        cyc(0, 1, 0, 1, G1 | RD1 | OV, "bp_beat1");
        cyc(0, 1, 0, 1, G1 | RD1 | OV, "bp_beat2");
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, G1 | OV, $sformatf("bp_stall%0d", i));
        cyc(0, 1, 0, 1, G1 | RD1 | OV, "bp_beat3");
        cyc(0, 1, 0, 1, G1 | RD1 | OV | PL, "bp_beat4_last");
        cyc(0, 0, 0, 1, G1, "bp_after");

        // requester 1 drops mid-packet while requester 2 waits
        cyc(1, 0, 0, 1, G1, "drop_reset_1");
        cyc(1, 0, 0, 1, Z, "drop_reset_2");
        cyc(0, 1, 1, 1, Z, "drop_c0");
        cyc(0, 1, 1, 1, G1 | RD1 | OV, "drop_beat1");
        cyc(0, 0, 1, 1, G1, "drop_hold1");
        cyc(0, 0, 1, 1, G1, "drop_hold2");
        cyc(0, 1, 1, 1, G1 | RD1 | OV, "drop_beat2");
        cyc(0, 1, 1, 1, G1 | RD1 | OV, "drop_beat3");
        cyc(0, 1, 1, 1, G1 | RD1 | OV | PL, "drop_beat4_last");
        cyc(0, 0, 1, 1, G2 | RD2 | SEL | OV, "drop_gnt2_beat1");

        // reset during beat 3 of requester 2's packet
        cyc(0, 0, 1, 1, G2 | RD2 | SEL | OV, "mrst_beat2");
        cyc(1, 0, 1, 1, G2 | RD2 | SEL | OV, "mrst_beat3_reset");
        cyc(0, 1, 1, 1, Z, "mrst_idle");
        cyc(0, 1, 1, 1, G1 | RD1 | OV, "mrst_req1_first");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
